// File: rtl/fir_filter_serial.sv
// Time-multiplexed FIR filter: one multiplier and accumulator stepped over TAPS runtime-loadable coefficients.
// Define FIR_SAT_EN to saturate the scaled output instead of wrapping it.
module fir_filter_serial #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   data_out,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_err
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
  localparam logic signed [COEF_W-1:0] H_UNITY = COEF_W'(1) << SHIFT;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, LOAD, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [COEF_W-1:0]  h_q [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic signed [DATA_W-1:0]  dout_q, dout_d;
  logic                      coef_err_q;

  logic                      accept;
  logic                      coefInRange;
  logic signed [PROD_W-1:0]  product;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  scaled;

  assign coefInRange = int'(coef_addr) < TAPS;
  assign product     = x_q[idx_q] * h_q[idx_q];
  assign shifted     = acc_q >>> SHIFT;

`ifdef FIR_SAT_EN
  always_comb begin
    scaled = shifted[DATA_W-1:0];
    if (shifted > OUT_MAX)      scaled = OUT_MAX[DATA_W-1:0];
    else if (shifted < OUT_MIN) scaled = OUT_MIN[DATA_W-1:0];
  end
`else
  assign scaled = shifted[DATA_W-1:0];
`endif

  // Next-state logic; the tap index walks 0..TAPS-1 so LOAD follows exactly TAPS MAC cycles.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    dout_d   = dout_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{AW{product[PROD_W-1]}}, product};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = LOAD;
      end
      LOAD: begin
        dout_d  = scaled;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Coefficient writes only land in IDLE, ahead of a same-edge accept, so that sample sees them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      dout_q     <= '0;
      coef_err_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= (i == 0) ? H_UNITY : '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      dout_q     <= dout_d;
      coef_err_q <= coef_we && (state_q != IDLE);
      if (coef_we && (state_q == IDLE) && coefInRange) h_q[coef_addr] <= coef_data;
      if (accept) begin
        x_q[0] <= data_in;
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
      end
    end
  end

  assign out_valid = (state_q == OUT);
  assign data_out  = dout_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_filter_serial.sv
// Self-checking bench for fir_filter_serial (TAPS=4) against a plain-arithmetic convolution model.
// Honours FIR_SAT_EN for the expected overflow behaviour.
module tb_fir_filter_serial;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 4;
  localparam int SHIFT  = 14;
  localparam int AW     = $clog2(TAPS);

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic signed [DATA_W-1:0]  data_in = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic signed [DATA_W-1:0]  data_out;
  logic                      coef_we = 1'b0;
  logic [AW-1:0]             coef_addr = '0;
  logic signed [COEF_W-1:0]  coef_data = '0;
  logic                      coef_err;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  longint mHist[TAPS];
  longint mCoef[TAPS];

  fir_filter_serial #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mHist[i] = 0;
      mCoef[i] = 0;
    end
    mCoef[0] = longint'(1) << SHIFT;
  endfunction

  // Convolution over the sample history, floor-scaled, then clamped or wrapped into DATA_W bits.
  function automatic longint model_push(longint s);
    longint sum, sh, lim;
    for (int i = TAPS - 1; i > 0; i--) mHist[i] = mHist[i-1];
    mHist[0] = s;
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += mHist[i] * mCoef[i];
    sh  = sum >>> SHIFT;
    lim = longint'(1) << (DATA_W - 1);
`ifdef FIR_SAT_EN
    if (sh > lim - 1) sh = lim - 1;
    else if (sh < -lim) sh = -lim;
`else
    sh = ((sh % (2 * lim)) + 2 * lim) % (2 * lim);
    if (sh >= lim) sh -= 2 * lim;
`endif
    return sh;
  endfunction

  task automatic reset_dut();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    out_ready = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic write_coef(input int a, input longint d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    tick();
    coef_we = 1'b0;
    mCoef[a] = d;
  endtask

  task automatic send_sample(input longint d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    data_in  = DATA_W'(d);
    for (int n = 0; n < 100 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b required 1 within 100 cycles", in_ready);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("[TB] FAIL output_timeout: out_valid=%0b required 1 within 100 cycles", out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_reset();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b required 0", out_valid); end
    if (data_out !== '0) begin errors++; $display("[TB] FAIL reset_data_out: got %0d required 0", data_out); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready); end
    if (coef_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_coef_err: got %0b required 0", coef_err); end
  endtask

  task automatic test_passthrough();
    longint samples[2] = '{1000, -2500};
    longint expected;
    int lat;
    reset_dut();
    foreach (samples[k]) begin
      expected = model_push(samples[k]);
      in_valid = 1'b1;
      data_in  = DATA_W'(samples[k]);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL pass_ready_before: got %0b required 1", in_ready); end
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL pass_busy_ready: got %0b required 0 at edge %0d", in_ready, lat); end
        tick();
        lat++;
      end
      checks += 3;
      if (lat != 5) begin errors++; $display("[TB] FAIL pass_latency: got %0d edges required 5", lat); end
      if (longint'(data_out) != samples[k] || longint'(data_out) != expected)
        begin errors++; $display("[TB] FAIL pass_data: got %0d required %0d", data_out, samples[k]); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL pass_out_ready: got %0b required 0", in_ready); end
      tick();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL pass_ready_after: got %0b required 1", in_ready); end
    end
  endtask

  task automatic test_moving_average();
    longint required[4] = '{1000, 2000, 3000, 4000};
    int lat;
    reset_dut();
    for (int i = 0; i < TAPS; i++) write_coef(i, 4096);
    for (int k = 0; k < 4; k++) begin
      void'(model_push(4000));
      send_sample(4000);
      wait_valid(lat);
      checks++;
      if (longint'(data_out) != required[k]) begin errors++; $display("[TB] FAIL mavg_data[%0d]: got %0d required %0d", k, data_out, required[k]); end
      tick();
    end
  endtask

  task automatic test_overflow();
    longint expected, fourth;
    int lat;
`ifdef FIR_SAT_EN
    fourth = 32767;
`else
    fourth = -12;
`endif
    reset_dut();
    for (int i = 0; i < TAPS; i++) write_coef(i, 16383);
    for (int k = 0; k < 4; k++) begin
      expected = model_push(32767);
      send_sample(32767);
      wait_valid(lat);
      checks++;
      if (longint'(data_out) != expected) begin errors++; $display("[TB] FAIL ovf_data[%0d]: got %0d required %0d", k, data_out, expected); end
      if (k == 3) begin
        checks++;
        if (longint'(data_out) != fourth) begin errors++; $display("[TB] FAIL ovf_fourth: got %0d required %0d", data_out, fourth); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    reset_dut();
    out_ready = 1'b0;
    send_sample(777);
    wait_valid(lat);
    for (int n = 0; n < 10; n++) begin
      tick();
      checks += 3;
      if (data_out !== 16'sd777) begin errors++; $display("[TB] FAIL bp_data: got %0d required 777", data_out); end
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %0b required 1", out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %0b required 0", in_ready); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %0b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %0b required 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_coef_busy();
    int lat;
    reset_dut();
    send_sample(300);
    coef_we = 1'b1; coef_addr = '0; coef_data = '0;
    tick();
    coef_we = 1'b0;
    checks++;
    if (coef_err !== 1'b1) begin errors++; $display("[TB] FAIL busy_err_pulse: got %0b required 1", coef_err); end
    tick();
    checks++;
    if (coef_err !== 1'b0) begin errors++; $display("[TB] FAIL busy_err_clear: got %0b required 0", coef_err); end
    wait_valid(lat);
    checks++;
    if (data_out !== 16'sd300) begin errors++; $display("[TB] FAIL busy_first: got %0d required 300", data_out); end
    tick();
    send_sample(1234);
    wait_valid(lat);
    checks++;
    if (data_out !== 16'sd1234) begin errors++; $display("[TB] FAIL busy_next: got %0d required 1234", data_out); end
    tick();
    // Write and accept on the same IDLE edge: the new h[0]=0 must already apply.
    coef_we = 1'b1; coef_addr = '0; coef_data = '0;
    in_valid = 1'b1; data_in = 16'sd555;
    tick();
    coef_we = 1'b0; in_valid = 1'b0;
    checks++;
    if (coef_err !== 1'b0) begin errors++; $display("[TB] FAIL idle_write_err: got %0b required 0", coef_err); end
    wait_valid(lat);
    checks++;
    if (data_out !== '0) begin errors++; $display("[TB] FAIL idle_write_data: got %0d required 0", data_out); end
    tick();
  endtask

  task automatic test_reset_mid_mac();
    int lat;
    reset_dut();
    send_sample(9000);
    wait_valid(lat);
    checks++;
    if (data_out !== 16'sd9000) begin errors++; $display("[TB] FAIL rst_pre_data: got %0d required 9000", data_out); end
    tick();
    send_sample(8000);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mac_valid: got %0b required 0", out_valid); end
    if (data_out !== '0) begin errors++; $display("[TB] FAIL rst_mac_data: got %0d required 0", data_out); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mac_ready: got %0b required 1", in_ready); end
    send_sample(500);
    wait_valid(lat);
    checks++;
    if (data_out !== 16'sd500) begin errors++; $display("[TB] FAIL rst_post_data: got %0d required 500", data_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    longint expq[$];
    longint got;
    int accepts[$];
    reset_dut();
    in_valid = 1'b1;
    for (int n = 0; n < 60 && (accepts.size() < 3 || expq.size() > 0); n++) begin
      in_valid = (accepts.size() < 3);
      data_in  = DATA_W'(1000 * (accepts.size() + 1));
      if (in_valid && in_ready) begin
        accepts.push_back(cycle);
        expq.push_back(model_push(longint'(data_in)));
      end
      if (out_valid && out_ready && expq.size() > 0) begin
        got = expq.pop_front();
        checks++;
        if (longint'(data_out) != got) begin errors++; $display("[TB] FAIL b2b_data: got %0d required %0d", data_out, got); end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (accepts.size() != 3 || expq.size() != 0) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d accepts %0d pending required 3 accepts 0 pending", accepts.size(), expq.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (accepts[k] - accepts[k-1] != TAPS + 3) begin
          errors++; $display("[TB] FAIL b2b_period: got %0d required %0d", accepts[k] - accepts[k-1], TAPS + 3);
        end
      end
    end
  endtask

  task automatic test_random();
    longint expq[$];
    longint got;
    reset_dut();
    for (int i = 0; i < TAPS; i++) write_coef(i, longint'($urandom_range(0, 16383)) - 8192);
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      data_in   = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) expq.push_back(model_push(longint'(data_in)));
      if (out_valid && in_ready) begin
        checks++; errors++;
        $display("[TB] FAIL rand_ready_in_out: in_ready=%0b required 0 while out_valid", in_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("[TB] FAIL rand_spurious: got output %0d required none", data_out);
        end else begin
          got = expq.pop_front();
          if (longint'(data_out) != got) begin errors++; $display("[TB] FAIL rand_data: got %0d required %0d", data_out, got); end
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && expq.size() > 0; n++) begin
      if (out_valid) begin
        got = expq.pop_front();
        checks++;
        if (longint'(data_out) != got) begin errors++; $display("[TB] FAIL rand_drain: got %0d required %0d", data_out, got); end
      end
      tick();
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("[TB] FAIL rand_pending: got %0d outputs outstanding required 0", expq.size()); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_moving_average();
    test_overflow();
    test_backpressure();
    test_coef_busy();
    test_reset_mid_mac();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
